// File: rtl/dsp_addsub_unit_pkg.sv
// Shared constants for the add/subtract unit: default datapath width and
// bit positions inside the six-bit flag vector.
package dsp_addsub_unit_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int FLAG_W    = 6;

  localparam int FLAG_CARRY  = 5;
  localparam int FLAG_BORROW = 4;
  localparam int FLAG_AOVF   = 3;
  localparam int FLAG_SOVF   = 2;
  localparam int FLAG_ZERO   = 1;
  localparam int FLAG_LT     = 0;

endpackage

// File: rtl/dsp_addsub_unit_adder_core.sv
// Plain WIDTH-bit adder with carry in/out; the subtract path reuses it
// by feeding the inverted B operand and a carry-in of one.
module dsp_adder_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  logic [WIDTH:0] total_s;

  assign total_s = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign result  = total_s[WIDTH-1:0];
  assign cout    = total_s[WIDTH];

endmodule

// File: rtl/dsp_addsub_unit.sv
// Zero-latency add/subtract results and flags for the ALU, plus a
// one-cycle registered copy with a valid strobe for pipelined consumers.
module dsp_addsub_unit
  import dsp_addsub_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  a_in,
  input  logic [WIDTH-1:0]  b_in,
  input  logic              in_valid,
  output logic [WIDTH-1:0]  sum,
  output logic [WIDTH-1:0]  sub,
  output logic              carry_out,
  output logic              borrow_out,
  output logic              add_ovf,
  output logic              sub_ovf,
  output logic              sub_zero,
  output logic              sub_lt,
  output logic [WIDTH-1:0]  sum_q,
  output logic [WIDTH-1:0]  sub_q,
  output logic [FLAG_W-1:0] flags_q,
  output logic              out_valid
);

  logic              add_cout_s;
  logic              sub_cout_s;
  logic [WIDTH-1:0]  b_inv_s;
  logic [FLAG_W-1:0] flags_s;

  logic [WIDTH-1:0]  sum_d;
  logic [WIDTH-1:0]  sub_d;
  logic [FLAG_W-1:0] flags_d;
  logic              out_valid_d;

  assign b_inv_s = ~b_in;

  dsp_adder_core #(.WIDTH(WIDTH)) u_add (
    .a      (a_in),
    .b      (b_in),
    .cin    (1'b0),
    .result (sum),
    .cout   (add_cout_s)
  );

  dsp_adder_core #(.WIDTH(WIDTH)) u_sub (
    .a      (a_in),
    .b      (b_inv_s),
    .cin    (1'b1),
    .result (sub),
    .cout   (sub_cout_s)
  );

  // A no-carry out of A + ~B + 1 means the subtraction borrowed.
  assign carry_out  = add_cout_s;
  assign borrow_out = ~sub_cout_s;
  assign add_ovf    = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (sum[WIDTH-1] != a_in[WIDTH-1]);
  assign sub_ovf    = (a_in[WIDTH-1] != b_in[WIDTH-1]) && (sub[WIDTH-1] != a_in[WIDTH-1]);
  assign sub_zero   = (sub == {WIDTH{1'b0}});
  assign sub_lt     = sub[WIDTH-1] ^ sub_ovf;

  assign flags_s[FLAG_CARRY]  = carry_out;
  assign flags_s[FLAG_BORROW] = borrow_out;
  assign flags_s[FLAG_AOVF]   = add_ovf;
  assign flags_s[FLAG_SOVF]   = sub_ovf;
  assign flags_s[FLAG_ZERO]   = sub_zero;
  assign flags_s[FLAG_LT]     = sub_lt;

  // Next-state for the output stage: capture on in_valid, otherwise hold.
  always_comb begin
    sum_d       = sum_q;
    sub_d       = sub_q;
    flags_d     = flags_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      sum_d   = sum;
      sub_d   = sub;
      flags_d = flags_s;
    end else begin
      sum_d   = sum_q;
      sub_d   = sub_q;
      flags_d = flags_q;
    end
  end

  // Output register stage, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q     <= {WIDTH{1'b0}};
      sub_q     <= {WIDTH{1'b0}};
      flags_q   <= {FLAG_W{1'b0}};
      out_valid <= 1'b0;
    end else begin
      sum_q     <= sum_d;
      sub_q     <= sub_d;
      flags_q   <= flags_d;
      out_valid <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_dsp_addsub_unit.sv
// Randomized and directed self-checking bench for dsp_addsub_unit against
// an arithmetic reference model.
module tb_dsp_addsub_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a_in, b_in;
  logic        in_valid;
  logic [31:0] sum, sub, sum_q, sub_q;
  logic        carry_out, borrow_out, add_ovf, sub_ovf, sub_zero, sub_lt;
  logic [5:0]  flags_q;
  logic        out_valid;

  int checks = 0;
  int errors = 0;

  logic [69:0] exp_reg;
  logic        exp_valid;

  always #5 clk = ~clk;

  dsp_addsub_unit dut (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in), .in_valid(in_valid),
    .sum(sum), .sub(sub), .carry_out(carry_out), .borrow_out(borrow_out),
    .add_ovf(add_ovf), .sub_ovf(sub_ovf), .sub_zero(sub_zero), .sub_lt(sub_lt),
    .sum_q(sum_q), .sub_q(sub_q), .flags_q(flags_q), .out_valid(out_valid)
  );

  wire [69:0] obs_comb = {sum, sub, carry_out, borrow_out, add_ovf, sub_ovf, sub_zero, sub_lt};
  wire [69:0] obs_reg  = {sum_q, sub_q, flags_q};

  // Reference: exact integer arithmetic, range checks for overflow.
  function automatic logic [69:0] ref_model(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ua, ub;
    longint      sa, sb, s_add, s_sub;
    logic [31:0] s, d;
    logic        c, br, ao, so, z, lt;
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s_add = sa + sb;
    s_sub = sa - sb;
    s  = 32'((ua + ub) % 64'h1_0000_0000);
    d  = 32'((ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000);
    c  = (ua + ub) >= 64'h1_0000_0000;
    br = ua < ub;
    ao = (s_add > 64'sd2147483647) || (s_add < -64'sd2147483648);
    so = (s_sub > 64'sd2147483647) || (s_sub < -64'sd2147483648);
    z  = (a == b);
    lt = (sa < sb);
    return {s, d, c, br, ao, so, z, lt};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; a_in = 32'd0; b_in = 32'd0;
    #1;
    checks++;
    if ({obs_reg, out_valid} !== 71'd0) begin
      errors++;
      $display("FAIL reset_regs: got %h required 0", {obs_reg, out_valid});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] va [0:7];
    logic [31:0] vb [0:7];
    va = '{32'd5, 32'hFFFFFFFF, 32'd0, 32'h7FFFFFFF, 32'h80000000, 32'h12345678, 32'h80000000, 32'h0};
    vb = '{32'd3, 32'd1, 32'd1, 32'd1, 32'd1, 32'h12345678, 32'h7FFFFFFF, 32'h0};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a_in = va[i]; b_in = vb[i];
      #1;
      checks++;
      if (obs_comb !== ref_model(va[i], vb[i])) begin
        errors++;
        $display("FAIL directed_%0d: got %h required %h", i, obs_comb, ref_model(va[i], vb[i]));
      end
    end
    // Hand-computed anchors independent of the model.
    @(negedge clk);
    a_in = 32'd5; b_in = 32'd3; #1;
    checks++;
    if (obs_comb !== {32'd8, 32'd2, 6'b000000}) begin
      errors++;
      $display("FAIL anchor_5_3: got %h required %h", obs_comb, {32'd8, 32'd2, 6'b000000});
    end
    a_in = 32'h7FFFFFFF; b_in = 32'd1; #1;
    checks++;
    if (obs_comb !== {32'h80000000, 32'h7FFFFFFE, 6'b001000}) begin
      errors++;
      $display("FAIL anchor_max_pos: got %h required %h", obs_comb, {32'h80000000, 32'h7FFFFFFE, 6'b001000});
    end
  endtask

  task automatic test_random_comb();
    logic [31:0] ra, rb;
    for (int i = 0; i < 200; i++) begin
      ra = $urandom();
      rb = (i % 10 == 0) ? ra : $urandom();
      if (i % 7 == 0) rb = {ra[31], rb[30:0]};
      a_in = ra; b_in = rb;
      #1;
      checks++;
      if (obs_comb !== ref_model(ra, rb)) begin
        errors++;
        $display("FAIL random_comb a=%h b=%h: got %h required %h", ra, rb, obs_comb, ref_model(ra, rb));
      end
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    a_in = 32'd10; b_in = 32'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, sum_q, sub_q} !== {1'b1, 32'd14, 32'd6}) begin
      errors++;
      $display("FAIL reg_capture: got %h required %h", {out_valid, sum_q, sub_q}, {1'b1, 32'd14, 32'd6});
    end
    @(negedge clk);
    in_valid = 1'b0; a_in = 32'd99; b_in = 32'd1;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, sum_q, sub_q} !== {1'b0, 32'd14, 32'd6}) begin
      errors++;
      $display("FAIL reg_hold: got %h required %h", {out_valid, sum_q, sub_q}, {1'b0, 32'd14, 32'd6});
    end
    exp_reg = ref_model(32'd10, 32'd4);
  endtask

  task automatic test_back_to_back();
    logic [31:0] ra, rb;
    logic        v;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      ra = $urandom(); rb = $urandom();
      v = (i < 10) ? 1'b1 : 1'($urandom_range(1, 0));
      a_in = ra; b_in = rb; in_valid = v;
      @(posedge clk); #1;
      if (v) exp_reg = ref_model(ra, rb);
      exp_valid = v;
      checks++;
      if ({out_valid, obs_reg} !== {exp_valid, exp_reg}) begin
        errors++;
        $display("FAIL stream_%0d: got %h required %h", i, {out_valid, obs_reg}, {exp_valid, exp_reg});
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    a_in = 32'hDEADBEEF; b_in = 32'h00C0FFEE; in_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_valid: got %b required 1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, obs_reg} !== 71'd0) begin
      errors++;
      $display("FAIL async_reset: got %h required 0", {out_valid, obs_reg});
    end
    checks++;
    if (obs_comb !== ref_model(32'hDEADBEEF, 32'h00C0FFEE)) begin
      errors++;
      $display("FAIL comb_during_reset: got %h required %h", obs_comb, ref_model(32'hDEADBEEF, 32'h00C0FFEE));
    end
    @(negedge clk);
    rst_n = 1'b1;
    a_in = 32'h80000000; b_in = 32'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, obs_reg} !== {1'b1, ref_model(32'h80000000, 32'd1)}) begin
      errors++;
      $display("FAIL first_edge_after_reset: got %h required %h", {out_valid, obs_reg}, {1'b1, ref_model(32'h80000000, 32'd1)});
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    exp_reg   = 70'd0;
    exp_valid = 1'b0;
    test_reset();
    test_directed();
    test_random_comb();
    test_registered();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
